// File: rtl/pc_call_stack.sv
// Fetch-stage program counter with step, relative branch and absolute jump,
// plus call/ret through an internal return-address stack with sticky error flags.
module pc_call_stack #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 8,
    parameter logic [WIDTH-1:0] INC_STEP  = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         inc,
    input  logic                         jump,
    input  logic                         branch,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WIDTH-1:0]             target,
    input  logic [WIDTH-1:0]             br_offset,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int unsigned    SPW     = $clog2(DEPTH + 1);
    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             push_en;
    logic             ovf_evt;
    logic             unf_evt;
    logic [WIDTH-1:0] ret_addr;
    logic [SPW-1:0]   sp_dec;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;

    assign ret_addr = pc_q + INC_STEP;
    assign sp_dec   = sp_q - SP_ONE;
    assign push_idx = sp_q[AW-1:0];
    assign pop_idx  = sp_dec[AW-1:0];

    // Prioritised command decode: next PC, stack pointer, push request and error events.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        push_en = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (sp_q != SP_ZERO) begin
                pc_d = mem_q[pop_idx];
                sp_d = sp_dec;
            end else begin
                pc_d    = ret_addr;
                unf_evt = 1'b1;
            end
        end else if (call) begin
            pc_d = target;
            if (sp_q != SP_FULL) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_ONE;
            end else begin
                ovf_evt = 1'b1;
            end
        end else if (jump) begin
            pc_d = target;
        end else if (branch) begin
            pc_d = pc_q + br_offset;
        end else if (inc) begin
            pc_d = ret_addr;
        end else begin
            pc_d = pc_q;
        end

        // A fresh error event beats a simultaneous clear.
        if (err_clr) begin
            ovf_d = ovf_evt;
            unf_d = unf_evt;
        end else begin
            ovf_d = ovf_q | ovf_evt;
            unf_d = unf_q | unf_evt;
        end

        empty_d = (sp_d == SP_ZERO);
        full_d  = (sp_d == SP_FULL);
    end

    // PC, stack pointer, status and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            sp_q    <= SP_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            mem_q[push_idx] <= ret_addr;
        end
    end

    assign pc_out      = pc_q;
    assign sp          = sp_q;
    assign stack_empty = empty_q;
    assign stack_full  = full_q;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed vector table, overflow/LIFO
// sequence, and randomized commands compared against a queue-based model.
module tb_pc_call_stack;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 8;
    localparam logic [15:0] RV = 16'h0100;

    localparam logic [7:0] C_RST  = 8'h80;
    localparam logic [7:0] C_STL  = 8'h40;
    localparam logic [7:0] C_INC  = 8'h20;
    localparam logic [7:0] C_JMP  = 8'h10;
    localparam logic [7:0] C_BR   = 8'h08;
    localparam logic [7:0] C_CALL = 8'h04;
    localparam logic [7:0] C_RET  = 8'h02;
    localparam logic [7:0] C_CLR  = 8'h01;
    localparam logic [7:0] C_NONE = 8'h00;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] target;
        logic [15:0] off;
        logic [15:0] exp_pc;
        logic [3:0]  exp_sp;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, inc, jump, branch, call, ret, err_clr;
    logic [15:0] target, br_offset;
    logic [15:0] pc_out;
    logic [3:0]  sp;
    logic        stack_empty, stack_full, ovf_err, unf_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf, m_unf;

    vec_t vecs[25];

    pc_call_stack #(.WIDTH(W), .DEPTH(D), .INC_STEP(16'h0001), .RESET_VEC(RV)) dut (
        .clk(clk), .rst(rst), .stall(stall), .inc(inc), .jump(jump), .branch(branch),
        .call(call), .ret(ret), .target(target), .br_offset(br_offset), .err_clr(err_clr),
        .pc_out(pc_out), .sp(sp), .stack_empty(stack_empty), .stack_full(stack_full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] c, input logic [15:0] t, input logic [15:0] o,
                                input logic [15:0] p, input logic [3:0] s, input logic ov, input logic un);
        vec_t v;
        v.cmd = c; v.target = t; v.off = o; v.exp_pc = p; v.exp_sp = s; v.exp_ovf = ov; v.exp_unf = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic [15:0] t, input logic [15:0] o);
        {rst, stall, inc, jump, branch, call, ret, err_clr} = c;
        target    = t;
        br_offset = o;
    endtask

    // Reference behaviour: highest-priority command wins, stack is a plain queue.
    task automatic model_step();
        logic oe, ue;
        oe = 1'b0;
        ue = 1'b0;
        if (rst) begin
            m_pc = RV;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (stall) begin
                m_pc = m_pc;
            end else if (ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_pc = m_pc + 16'd1; ue = 1'b1; end
            end else if (call) begin
                if (m_stack.size() < D) m_stack.push_back(m_pc + 16'd1);
                else oe = 1'b1;
                m_pc = target;
            end else if (jump) m_pc = target;
            else if (branch) m_pc = m_pc + br_offset;
            else if (inc) m_pc = m_pc + 16'd1;
            m_ovf = err_clr ? oe : (m_ovf | oe);
            m_unf = err_clr ? ue : (m_unf | ue);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_pc",    32'(pc_out),      32'(m_pc));
        chk("model_sp",    32'(sp),          32'(m_stack.size()));
        chk("model_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        chk("model_full",  32'(stack_full),  32'(m_stack.size() == D));
        chk("model_ovf",   32'(ovf_err),     32'(m_ovf));
        chk("model_unf",   32'(unf_err),     32'(m_unf));
    endtask

    initial begin
        logic [7:0]  c;
        logic [15:0] exp_ret;
        drive(C_NONE, 16'h0000, 16'h0000);
        m_pc  = 16'h0000;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        vecs[0]  = mk(C_RST | C_INC,           16'h0000, 16'h0000, 16'h0100, 4'd0, 1'b0, 1'b0);
        vecs[1]  = mk(C_RST | C_INC,           16'h0000, 16'h0000, 16'h0100, 4'd0, 1'b0, 1'b0);
        vecs[2]  = mk(C_INC,                   16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b0, 1'b0);
        vecs[3]  = mk(C_JMP,                   16'hFFFF, 16'h0000, 16'hFFFF, 4'd0, 1'b0, 1'b0);
        vecs[4]  = mk(C_INC,                   16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        vecs[5]  = mk(C_INC,                   16'h0000, 16'h0000, 16'h0001, 4'd0, 1'b0, 1'b0);
        vecs[6]  = mk(C_BR,                    16'h0000, 16'hFFFE, 16'hFFFF, 4'd0, 1'b0, 1'b0);
        vecs[7]  = mk(C_JMP,                   16'h0010, 16'h0000, 16'h0010, 4'd0, 1'b0, 1'b0);
        vecs[8]  = mk(C_CALL,                  16'h0200, 16'h0000, 16'h0200, 4'd1, 1'b0, 1'b0);
        vecs[9]  = mk(C_CALL,                  16'h0300, 16'h0000, 16'h0300, 4'd2, 1'b0, 1'b0);
        vecs[10] = mk(C_RET,                   16'h0000, 16'h0000, 16'h0201, 4'd1, 1'b0, 1'b0);
        vecs[11] = mk(C_RET,                   16'h0000, 16'h0000, 16'h0011, 4'd0, 1'b0, 1'b0);
        vecs[12] = mk(C_JMP,                   16'h0040, 16'h0000, 16'h0040, 4'd0, 1'b0, 1'b0);
        vecs[13] = mk(C_RET,                   16'h0000, 16'h0000, 16'h0041, 4'd0, 1'b0, 1'b1);
        vecs[14] = mk(C_CLR,                   16'h0000, 16'h0000, 16'h0041, 4'd0, 1'b0, 1'b0);
        vecs[15] = mk(C_RET,                   16'h0000, 16'h0000, 16'h0042, 4'd0, 1'b0, 1'b1);
        vecs[16] = mk(C_CLR | C_RET,           16'h0000, 16'h0000, 16'h0043, 4'd0, 1'b0, 1'b1);
        vecs[17] = mk(C_CLR,                   16'h0000, 16'h0000, 16'h0043, 4'd0, 1'b0, 1'b0);
        vecs[18] = mk(C_CALL,                  16'h0500, 16'h0000, 16'h0500, 4'd1, 1'b0, 1'b0);
        vecs[19] = mk(C_STL | C_CALL | C_INC,  16'h0600, 16'h0000, 16'h0500, 4'd1, 1'b0, 1'b0);
        vecs[20] = mk(C_RET | C_CALL | C_JMP,  16'h0800, 16'h0000, 16'h0044, 4'd0, 1'b0, 1'b0);
        vecs[21] = mk(C_CALL,                  16'h0900, 16'h0000, 16'h0900, 4'd1, 1'b0, 1'b0);
        vecs[22] = mk(C_RST | C_CALL,          16'h0A00, 16'h0000, 16'h0100, 4'd0, 1'b0, 1'b0);
        vecs[23] = mk(C_RET,                   16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b0, 1'b1);
        vecs[24] = mk(C_STL | C_RET | C_CLR,   16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].cmd, vecs[i].target, vecs[i].off);
            tick();
            chk($sformatf("vec%0d_pc", i),    32'(pc_out),      32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_sp", i),    32'(sp),          32'(vecs[i].exp_sp));
            chk($sformatf("vec%0d_empty", i), 32'(stack_empty), 32'(vecs[i].exp_sp == 4'd0));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf_err),     32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_unf", i),   32'(unf_err),     32'(vecs[i].exp_unf));
        end

        // Overflow: nine calls from 0101, the last one finds the stack full.
        for (int i = 0; i < 9; i++) begin
            drive(C_CALL, 16'h1000 + 16'(i * 16), 16'h0000);
            tick();
        end
        chk("ovf_pc",   32'(pc_out),     32'h1080);
        chk("ovf_sp",   32'(sp),         32'd8);
        chk("ovf_full", 32'(stack_full), 32'd1);
        chk("ovf_flag", 32'(ovf_err),    32'd1);

        // Unwind in LIFO order.
        for (int k = 0; k < 8; k++) begin
            drive(C_RET, 16'h0000, 16'h0000);
            tick();
            exp_ret = (k < 7) ? (16'h1061 - 16'(k * 16)) : 16'h0102;
            chk($sformatf("lifo%0d_pc", k), 32'(pc_out), 32'(exp_ret));
        end
        chk("lifo_empty", 32'(stack_empty), 32'd1);
        chk("lifo_ovf",   32'(ovf_err),     32'd1);
        drive(C_CLR, 16'h0000, 16'h0000);
        tick();
        chk("clr_ovf", 32'(ovf_err), 32'd0);

        // Randomized commands against the model.
        for (int n = 0; n < 3000; n++) begin
            c = 8'h00;
            c[7] = ($urandom_range(0, 63) == 0);
            c[6] = ($urandom_range(0, 7) == 0);
            c[5] = ($urandom_range(0, 3) == 0);
            c[4] = ($urandom_range(0, 5) == 0);
            c[3] = ($urandom_range(0, 5) == 0);
            c[2] = ($urandom_range(0, 2) == 0);
            c[1] = ($urandom_range(0, 3) == 0);
            c[0] = ($urandom_range(0, 7) == 0);
            drive(c, 16'($urandom), 16'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
